regfile_wb_arb: RTL and testbench

Integer register file with a single shared write port arbitrated between the EXU and LSU writeback requesters. It also emits a registered commit record per retired write for the difftest checker. The block sits at the writeback stage. It exports the full architectural register state as a flat bus that feeds the difftest register view. A checker-driven hold input freezes commits while the host-side reference model is stepping.

---
 rtl/npc_pkg.sv | 19 +
 rtl/regfile_wb_arb_if.sv | 29 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/regfile_wb_arb.sv | 81 ++++++++
 tb/tb_regfile_wb_arb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared types and sizes for the writeback-stage register file and its arbiter.
package npc_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   pc;
  } wb_req_t;

  typedef enum logic {
    PRIO_EXU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Writeback request bundle for the EXU and LSU requesters sharing one write port.
interface regfile_wb_arb_if;
  import npc_pkg::*;

  logic              exu_wb_valid;
  logic              exu_wb_ready;
  logic [REG_AW-1:0] exu_wb_rd;
  logic [XLEN-1:0]   exu_wb_data;
  logic [XLEN-1:0]   exu_wb_pc;

  logic              lsu_wb_valid;
  logic              lsu_wb_ready;
  logic [REG_AW-1:0] lsu_wb_rd;
  logic [XLEN-1:0]   lsu_wb_data;
  logic [XLEN-1:0]   lsu_wb_pc;

  modport master (
    output exu_wb_valid, exu_wb_rd, exu_wb_data, exu_wb_pc,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data, lsu_wb_pc,
    input  exu_wb_ready, lsu_wb_ready
  );

  modport slave (
    input  exu_wb_valid, exu_wb_rd, exu_wb_data, exu_wb_pc,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data, lsu_wb_pc,
    output exu_wb_ready, lsu_wb_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is EXU, bit 1 is LSU.
//   state    | meaning
//   PRIO_EXU | EXU wins a tie
//   PRIO_LSU | LSU wins a tie
module rr_arb2
  import npc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  prio_e      prio_q;
  prio_e      prio_d;
  logic [1:0] elig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= PRIO_EXU;
    else     prio_q <= prio_d;
  end

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    elig   = req & {2{~hold}};
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_q == PRIO_EXU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // pointer passes to whoever lost (or did not ask)
    if (gnt[0])      prio_d = PRIO_LSU;
    else if (gnt[1]) prio_d = PRIO_EXU;
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Integer register file with one arbitrated write port, a commit record for the
// difftest checker, and the whole architectural state exported as a flat bus.
module regfile_wb_arb
  import npc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arb_if.slave        wb,
  input  logic                   diff_hold,
  input  logic [REG_AW-1:0]      raddr1,
  input  logic [REG_AW-1:0]      raddr2,
  output logic [XLEN-1:0]        rdata1,
  output logic [XLEN-1:0]        rdata2,
  output logic [NREG*XLEN-1:0]   rf_flat,
  output logic                   commit_valid,
  output logic [XLEN-1:0]        commit_pc,
  output logic [REG_AW-1:0]      commit_rd,
  output logic [63:0]            commit_cnt
);

  logic [XLEN-1:0] rf [NREG];
  logic [1:0]      gnt;
  logic            wr_en;
  wb_req_t         exu_req;
  wb_req_t         lsu_req;
  wb_req_t         win_req;

  assign exu_req = '{rd: wb.exu_wb_rd, data: wb.exu_wb_data, pc: wb.exu_wb_pc};
  assign lsu_req = '{rd: wb.lsu_wb_rd, data: wb.lsu_wb_data, pc: wb.lsu_wb_pc};

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({wb.lsu_wb_valid, wb.exu_wb_valid}),
    .hold (diff_hold),
    .gnt  (gnt)
  );

  assign wb.exu_wb_ready = gnt[0];
  assign wb.lsu_wb_ready = gnt[1];
  assign wr_en           = |gnt;
  assign win_req         = gnt[1] ? lsu_req : exu_req;

  // x0 is never written, so a commit to rd 0 leaves storage untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en && (win_req.rd != '0)) begin
      rf[win_req.rd] <= win_req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_rd    <= '0;
      commit_cnt   <= '0;
    end else begin
      commit_valid <= wr_en;
      if (wr_en) begin
        commit_pc  <= win_req.pc;
        commit_rd  <= win_req.rd;
        commit_cnt <= commit_cnt + 64'd1;
      end
    end
  end

  // no write bypass: a same-cycle read sees the pre-write value
  assign rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    if (i == 0) begin : g_zero
      assign rf_flat[0 +: XLEN] = '0;
    end else begin : g_reg
      assign rf_flat[i*XLEN +: XLEN] = rf[i];
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomized bench for regfile_wb_arb against a behavioural register-file/arbiter model.
module tb_regfile_wb_arb;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arb_if wb ();

  logic              diff_hold;
  logic [4:0]        raddr1, raddr2;
  logic [31:0]       rdata1, rdata2;
  logic [1023:0]     rf_flat;
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic [4:0]        commit_rd;
  logic [63:0]       commit_cnt;

  regfile_wb_arb dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb),
    .diff_hold    (diff_hold),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .rf_flat      (rf_flat),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_cnt   (commit_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // stimulus state: a request stays posted until the model says it was granted
  bit        e_v, l_v, hold;
  bit [4:0]  e_rd, l_rd, ra1, ra2;
  bit [31:0] e_data, l_data, e_pc, l_pc;

  // reference model
  bit [31:0] m_rf [32];
  bit        m_lsu_turn;
  bit        m_cv;
  bit [31:0] m_cpc;
  bit [4:0]  m_crd;
  bit [63:0] m_cnt;
  bit        ge, gl;

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_lsu_turn = 1'b0;
    m_cv  = 1'b0;
    m_cpc = '0;
    m_crd = '0;
    m_cnt = '0;
  endtask

  task automatic new_exu(input bit [4:0] rd, input bit [31:0] data);
    e_v = 1'b1; e_rd = rd; e_data = data; e_pc = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_lsu(input bit [4:0] rd, input bit [31:0] data);
    l_v = 1'b1; l_rd = rd; l_data = data; l_pc = $urandom & 32'hFFFF_FFFC;
  endtask

  // one clock: drive, check pre-edge view, advance, update model, return at negedge
  task automatic cycle();
    bit [4:0]  w_rd;
    bit [31:0] w_data, w_pc;
    wb.exu_wb_valid = e_v; wb.exu_wb_rd = e_rd; wb.exu_wb_data = e_data; wb.exu_wb_pc = e_pc;
    wb.lsu_wb_valid = l_v; wb.lsu_wb_rd = l_rd; wb.lsu_wb_data = l_data; wb.lsu_wb_pc = l_pc;
    diff_hold = hold; raddr1 = ra1; raddr2 = ra2;
    #1;
    ge = e_v && !hold && (!l_v || !m_lsu_turn);
    gl = l_v && !hold && (!e_v ||  m_lsu_turn);
    chk("exu_ready", wb.exu_wb_ready, ge);
    chk("lsu_ready", wb.lsu_wb_ready, gl);
    chk("rdata1", rdata1, (ra1 == 0) ? 32'd0 : m_rf[ra1]);
    chk("rdata2", rdata2, (ra2 == 0) ? 32'd0 : m_rf[ra2]);
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_pc", commit_pc, m_cpc);
    chk("commit_rd", commit_rd, m_crd);
    chk("commit_cnt", commit_cnt, m_cnt);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_flat[%0d]", i), rf_flat[i*32 +: 32], m_rf[i]);
    @(posedge clk);
    if (!rst) begin
      if (ge || gl) begin
        w_rd   = ge ? e_rd   : l_rd;
        w_data = ge ? e_data : l_data;
        w_pc   = ge ? e_pc   : l_pc;
        if (w_rd != 0) m_rf[w_rd] = w_data;
        m_cv  = 1'b1;
        m_cpc = w_pc;
        m_crd = w_rd;
        m_cnt = m_cnt + 64'd1;
        m_lsu_turn = ge;
      end else begin
        m_cv = 1'b0;
      end
      if (ge) e_v = 1'b0;
      if (gl) l_v = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    e_v = 0; l_v = 0; hold = 0; ra1 = 0; ra2 = 0;
    e_rd = 0; l_rd = 0; e_data = 0; l_data = 0; e_pc = 0; l_pc = 0;
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // single EXU write
    new_exu(5'd5, 32'hDEADBEEF); e_pc = 32'h8000_0000; ra1 = 5'd5;
    cycle();
    chk("single_rdata1", rdata1, 32'hDEADBEEF);
    chk("single_cv", commit_valid, 1);
    chk("single_pc", commit_pc, 32'h8000_0000);
    chk("single_rd", commit_rd, 5);
    chk("single_cnt", commit_cnt, 1);

    // reset mid-run with a grant in flight
    new_exu(5'd9, 32'hCAFE_0009);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) chk("rst_flat", rf_flat[i*32 +: 32], 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_cv", commit_valid, 0);
    model_reset();
    cycle();
    rst = 1'b0;
    e_v = 1'b0;
    chk("rst_lost_write", rf_flat[9*32 +: 32], 0);
    chk("rst_lost_cnt", commit_cnt, 0);

    // contention: EXU rd1 vs LSU rd2, expect E,L,E,L
    for (int k = 0; k < 4; k++) begin
      if (!e_v && k < 3) new_exu(5'd1, $urandom);
      if (!l_v) new_lsu(5'd2, $urandom);
      cycle();
      chk("cont_order", commit_rd, (k % 2 == 1) ? 5'd2 : 5'd1);
    end
    chk("cont_cnt", commit_cnt, 4);

    // x0 write from LSU
    new_lsu(5'd0, 32'h1234); ra1 = 5'd0;
    cycle();
    chk("x0_rdata1", rdata1, 0);
    chk("x0_flat", rf_flat[31:0], 0);
    chk("x0_cv", commit_valid, 1);
    chk("x0_cnt", commit_cnt, 5);

    // hold with both valid; LSU won last so EXU is next
    new_exu(5'd3, 32'h3333); new_lsu(5'd4, 32'h4444); hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_cv", commit_valid, 0);
      chk("hold_cnt", commit_cnt, 5);
    end
    hold = 1'b0;
    cycle();
    chk("hold_release_rd", commit_rd, 3);
    cycle();
    chk("hold_second_rd", commit_rd, 4);

    // read/write same register in the same cycle
    ra1 = 5'd7;
    new_exu(5'd7, 32'hAA);
    cycle();
    chk("rw_first", rdata1, 32'hAA);
    new_exu(5'd7, 32'h55);
    cycle();
    chk("rw_after", rdata1, 32'h55);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!e_v && ($urandom_range(0, 1) == 1)) new_exu(5'($urandom_range(0, 31)), $urandom);
      if (!l_v && ($urandom_range(0, 1) == 1)) new_lsu(5'($urandom_range(0, 31)), $urandom);
      hold = ($urandom_range(0, 4) == 0);
      ra1  = 5'($urandom_range(0, 31));
      ra2  = 5'($urandom_range(0, 31));
      cycle();
    end
    hold = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
